// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA display-memory writer and scan reader.
package vga_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_VS,
      WRITE,
      FLUSH,
      DONE
   } wr_state_t;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int ADDR_W   = 19;
   localparam int PIX_W    = 8;

   localparam int DIM_W_MSB = 15;
   localparam int DIM_W_LSB = 8;
   localparam int DIM_H_MSB = 7;
   localparam int DIM_H_LSB = 0;

endpackage

// File: rtl/vga_frame_writer_if.sv
// Pixel stream in, display-memory write port out; master drives pixels, slave is the writer.
interface vga_frame_writer_if;
   import vga_pkg::*;

   logic              pix_valid;
   logic [PIX_W-1:0]  pix_data;
   logic              pix_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_wdata;

   modport master (
      output pix_valid, pix_data,
      input  pix_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  pix_valid, pix_data,
      output pix_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/vs_edge_detect.sv
// Falling-edge detector for the active-low vertical sync, shared with the VGA reader.
module vs_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic i_vs,
   output logic o_fall
);

   logic r_vs_prev;

   // Previous value resets low so a sync already held low never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) r_vs_prev <= 1'b0;
      else       r_vs_prev <= i_vs;
   end

   assign o_fall = r_vs_prev & ~i_vs;

endmodule

// File: rtl/vga_frame_writer.sv
// Writes one row-major frame of grey pixels into display memory, starting on a VS falling edge.
//
// state   | meaning
// IDLE    | waiting for start; dimensions latched on accept
// WAIT_VS | legal frame armed, waiting for a fresh VS falling edge
// WRITE   | accepting pixels, one registered memory write per transfer
// FLUSH   | last memory write on the bus, no more pixels accepted
// DONE    | one-cycle done pulse, then back to IDLE
module vga_frame_writer
   import vga_pkg::*;
#(
   parameter int                STRIDE    = H_ACTIVE,
   parameter int                MAX_ROWS  = V_ACTIVE,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [15:0]        dimensiones,
   input  logic               vertical_sync,
   vga_frame_writer_if.slave  pix_if,
   output logic               busy,
   output logic               done,
   output logic               dim_err
);

   wr_state_t         r_state;
   wr_state_t         w_state_nxt;

   logic [7:0]        r_w;
   logic [7:0]        r_h;
   logic [7:0]        r_col;
   logic [8:0]        r_row;
   logic [ADDR_W-1:0] r_row_base;
   logic              r_dim_err;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [PIX_W-1:0]  r_mem_wdata;

   logic [7:0]        w_dim_w;
   logic [7:0]        w_dim_h;
   logic              w_dim_bad;
   logic              w_accept;
   logic              w_ready;
   logic              w_xfer;
   logic              w_col_last;
   logic              w_row_last;
   logic              w_vs_fall;

   vs_edge_detect u_vs_edge (
      .clk    (clk),
      .reset  (reset),
      .i_vs   (vertical_sync),
      .o_fall (w_vs_fall)
   );

   assign w_dim_w    = dimensiones[DIM_W_MSB:DIM_W_LSB];
   assign w_dim_h    = dimensiones[DIM_H_MSB:DIM_H_LSB];
   assign w_dim_bad  = (w_dim_w == 8'd0) || (w_dim_h == 8'd0) ||
                       (int'({24'd0, w_dim_w}) > STRIDE) ||
                       (int'({24'd0, w_dim_h}) > MAX_ROWS);
   assign w_accept   = (r_state == IDLE) && start;
   assign w_xfer     = pix_if.pix_valid && w_ready;
   assign w_col_last = (r_col == (r_w - 8'd1));
   assign w_row_last = (r_row == ({1'b0, r_h} - 9'd1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = w_dim_bad ? DONE : WAIT_VS;
         end
         WAIT_VS: begin
            busy = 1'b1;
            if (w_vs_fall) w_state_nxt = WRITE;
         end
         WRITE: begin
            busy    = 1'b1;
            w_ready = 1'b1;
            if (w_xfer && w_col_last && w_row_last) w_state_nxt = FLUSH;
         end
         FLUSH: begin
            busy        = 1'b1;
            w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Address advances by addition only: row_base steps by STRIDE on each column wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_w         <= '0;
         r_h         <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_row_base  <= BASE_ADDR;
         r_dim_err   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= BASE_ADDR;
         r_mem_wdata <= '0;
      end else begin
         r_mem_we <= w_xfer;
         if (w_accept) begin
            r_w        <= w_dim_w;
            r_h        <= w_dim_h;
            r_dim_err  <= w_dim_bad;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= BASE_ADDR;
         end
         if (w_xfer) begin
            r_mem_addr  <= r_row_base + ADDR_W'(r_col);
            r_mem_wdata <= pix_if.pix_data;
            if (w_col_last) begin
               r_col      <= '0;
               r_row      <= r_row + 9'd1;
               r_row_base <= r_row_base + ADDR_W'(STRIDE);
            end else begin
               r_col <= r_col + 8'd1;
            end
         end
      end
   end

   assign pix_if.pix_ready = w_ready;
   assign pix_if.mem_we    = r_mem_we;
   assign pix_if.mem_addr  = r_mem_addr;
   assign pix_if.mem_wdata = r_mem_wdata;
   assign dim_err          = r_dim_err;

endmodule

// File: tb/tb_vga_frame_writer.sv
// Bench for vga_frame_writer: expected writes come from row-major arithmetic on the transfer index.
module tb_vga_frame_writer;
   import vga_pkg::*;

   localparam int STRIDE = 640;
   localparam int BASE   = 0;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] dimensiones;
   logic        vertical_sync;
   logic        busy;
   logic        done;
   logic        dim_err;

   vga_frame_writer_if pif ();

   vga_frame_writer #(
      .STRIDE    (640),
      .MAX_ROWS  (480),
      .BASE_ADDR ('0)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .dimensiones   (dimensiones),
      .vertical_sync (vertical_sync),
      .pix_if        (pif),
      .busy          (busy),
      .done          (done),
      .dim_err       (dim_err)
   );

   always #20 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int k;
   int fw;
   int fh;
   int exp_addr;
   int last_addr;
   int bound;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock; a transfer seen before the edge must appear as the k-th row-major write after it.
   task automatic tick();
      logic       x;
      logic [7:0] d;
      x = pif.pix_valid & pif.pix_ready;
      d = pif.pix_data;
      @(posedge clk);
      #1;
      if (x === 1'b1) begin
         exp_addr = BASE + (k / fw) * STRIDE + (k % fw);
         chk("we_after_xfer", 32'(pif.mem_we), 1);
         chk("mem_addr", 32'(pif.mem_addr), exp_addr);
         chk("mem_wdata", 32'(pif.mem_wdata), 32'(d));
         last_addr = exp_addr;
         k++;
      end else begin
         chk("we_without_xfer", 32'(pif.mem_we), 0);
      end
   endtask

   task automatic start_frame(input int w, input int h);
      fw          = w;
      fh          = h;
      k           = 0;
      dimensiones = {w[7:0], h[7:0]};
      start       = 1'b1;
      tick();
      start       = 1'b0;
      chk("dim_err_clear_on_start", 32'(dim_err), 0);
   endtask

   task automatic vs_edge();
      vertical_sync = 1'b1;
      tick();
      tick();
      vertical_sync = 1'b0;
      tick();
      chk("ready_after_vs", 32'(pif.pix_ready), 1);
   endtask

   // mode 0: continuous valid, data 10,11,...; mode 1: valid toggling; mode 2: random valid.
   task automatic write_pixels(input int mode, input bit poke_start);
      int n;
      int cyc;
      n   = fw * fh;
      cyc = 0;
      chk("busy_in_write", 32'(busy), 1);
      while (k < n && cyc < 4 * n + 100) begin
         case (mode)
            0:       pif.pix_valid = 1'b1;
            1:       pif.pix_valid = (cyc % 2 == 0);
            default: pif.pix_valid = 1'($urandom_range(0, 1));
         endcase
         pif.pix_data = (mode == 0) ? 8'(10 + cyc) : 8'($urandom);
         if (poke_start) begin
            start       = ($urandom_range(0, 99) == 0);
            dimensiones = 16'($urandom);
         end
         tick();
         chk("no_early_done", 32'(done), 0);
         cyc++;
      end
      start = 1'b0;
      chk("frame_write_count", k, n);
      chk("ready_low_in_flush", 32'(pif.pix_ready), 0);
      pif.pix_valid = 1'b1;
      tick();
      chk("done_pulse", 32'(done), 1);
      chk("busy_low_at_done", 32'(busy), 0);
      dimensiones = 16'h0202;
      start       = 1'b1;
      tick();
      start       = 1'b0;
      chk("done_one_cycle", 32'(done), 0);
      chk("start_in_done_ignored", 32'(busy), 0);
      pif.pix_valid = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      vertical_sync = 1'b1;
      dimensiones   = '0;
      pif.pix_valid = 1'b0;
      pif.pix_data  = '0;
      fw            = 1;
      fh            = 1;
      k             = 0;
      last_addr     = 0;
      repeat (3) tick();
      chk("rst_ready", 32'(pif.pix_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_dim_err", 32'(dim_err), 0);
      chk("rst_addr", 32'(pif.mem_addr), BASE);
      chk("rst_wdata", 32'(pif.mem_wdata), 0);
      reset = 1'b0;
      tick();

      // 4x2 continuous, data 10..17
      start_frame(4, 2);
      vs_edge();
      write_pixels(0, 1'b0);
      chk("t1_last_addr", last_addr, 643);

      // 4x2 with valid toggling
      start_frame(4, 2);
      vs_edge();
      write_pixels(1, 1'b0);
      chk("t2_last_addr", last_addr, 643);

      // zero width, then zero height: error path with no writes
      dimensiones = 16'h0003;
      start       = 1'b1;
      tick();
      start       = 1'b0;
      chk("w0_done", 32'(done), 1);
      chk("w0_dim_err", 32'(dim_err), 1);
      chk("w0_busy", 32'(busy), 0);
      tick();
      chk("w0_done_gone", 32'(done), 0);
      chk("w0_dim_err_sticky", 32'(dim_err), 1);
      dimensiones = 16'h0500;
      start       = 1'b1;
      tick();
      start       = 1'b0;
      chk("h0_done", 32'(done), 1);
      chk("h0_dim_err", 32'(dim_err), 1);
      tick();
      start_frame(3, 3);
      vs_edge();
      write_pixels(2, 1'b0);

      // VS already low at start needs a fresh edge; valid pixels meanwhile are dropped
      vertical_sync = 1'b0;
      tick();
      start_frame(5, 3);
      pif.pix_valid = 1'b1;
      pif.pix_data  = 8'hA5;
      repeat (5) begin
         tick();
         chk("vs_low_no_ready", 32'(pif.pix_ready), 0);
      end
      vertical_sync = 1'b1;
      tick();
      chk("vs_high_no_ready", 32'(pif.pix_ready), 0);
      vertical_sync = 1'b0;
      tick();
      chk("vs_fresh_edge_ready", 32'(pif.pix_ready), 1);
      chk("no_write_before_edge", k, 0);
      write_pixels(2, 1'b0);

      // reset after three writes of an 8x8 frame
      start_frame(8, 8);
      vs_edge();
      pif.pix_valid = 1'b1;
      bound = 0;
      while (k < 3 && bound < 20) begin
         pif.pix_data = 8'($urandom);
         tick();
         bound++;
      end
      chk("pre_reset_writes", k, 3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_we", 32'(pif.mem_we), 0);
      chk("abort_done", 32'(done), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ready", 32'(pif.pix_ready), 0);
      chk("abort_addr", 32'(pif.mem_addr), BASE);
      reset = 1'b0;
      repeat (4) begin
         tick();
         chk("abort_no_done", 32'(done), 0);
      end
      pif.pix_valid = 1'b0;
      start_frame(8, 8);
      vs_edge();
      write_pixels(2, 1'b0);
      chk("restart_last_addr", last_addr, 7 * STRIDE + 7);

      // random small frames
      repeat (4) begin
         start_frame($urandom_range(1, 20), $urandom_range(1, 10));
         vs_edge();
         write_pixels(2, 1'b0);
      end

      // full 255x255 with stray start pulses and dimension changes mid-frame
      start_frame(255, 255);
      vs_edge();
      write_pixels(0, 1'b1);
      chk("full_write_count", k, 65025);
      chk("full_last_addr", last_addr, 162814);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_frame_writer.md
Name: vga_frame_writer

Overview:
Write-side counterpart of the VGA scan reader. It accepts processed 8-bit grey pixels from the processing pipeline over a valid/ready stream. It writes them row-major into the display memory that the VGA block scans through its 19-bit DataAdr. Frame writes start only at a vertical-sync edge to avoid tearing, and address generation is incremental, with no multiplier.

Parameters:
STRIDE, 640, display memory words per line (VGA line width)
MAX_ROWS, 480, display lines available
BASE_ADDR, 0, 19-bit memory address of pixel (0,0)

Ports:
clk  in  1  system clock (the 25 MHz VGA clock domain)
reset  in  1  synchronous, active-high
start  in  1  request one frame write; sampled only in IDLE
dimensiones  in  16  image size; [15:8] width in pixels, [7:0] height in lines; latched on accepted start
vertical_sync  in  1  VGA VS, active low
pix_valid  in  1  pixel stream valid
pix_data  in  8  pixel value
pix_ready  out  1  writer accepts a pixel this cycle
mem_we  out  1  display-memory write enable
mem_addr  out  19  display-memory write address
mem_wdata  out  8  display-memory write data
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of frame
dim_err  out  1  sticky until next accepted start; dimensions rejected

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state=IDLE; pix_ready, mem_we, busy, done, dim_err = 0; mem_addr = BASE_ADDR; mem_wdata = 0.
- Reset asserted mid-frame aborts immediately. No further mem_we occurs, the partial frame is left in memory, and no done pulse is produced.
- States: IDLE, WAIT_VS, WRITE, FLUSH, DONE.
- IDLE, start=1:
  - Latch width W and height H; clear dim_err; busy=1.
  - If W=0, H=0, W>STRIDE or H>MAX_ROWS: set dim_err=1 and go to DONE with no writes.
  - Otherwise go to WAIT_VS.
- WAIT_VS: stay until a falling edge of vertical_sync (registered previous=1, current=0), then go to WRITE. A vertical_sync held low at entry does not count; a fresh edge is required.
- WRITE:
  - pix_ready=1.
  - A transfer is pix_valid & pix_ready in the same cycle.
  - On a transfer, the next cycle drives mem_we=1, mem_addr=row_base+col, mem_wdata=pix_data. The write is registered, latency 1.
  - No transfer means mem_we=0 in the next cycle. Bubbles are allowed indefinitely.
- Counters:
  - col runs 0..W-1. When col wraps, col=0, row++, row_base += STRIDE (19-bit add). row_base starts at BASE_ADDR.
  - On the transfer of pixel (W-1, H-1), drop pix_ready in the next cycle and go to FLUSH.
- FLUSH: the last mem_we is issued in this cycle; then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0 the same cycle, then IDLE.
- Dimension-error path: start cycle, DONE cycle (done=1), then IDLE.
- Ignored inputs:
  - start outside IDLE is ignored.
  - dimensiones changes after latching are ignored.
  - pix_valid outside WRITE is ignored: no transfer, no write.
- Simultaneous events: a start in the same cycle as done is not accepted (state is DONE, not IDLE).
- Widths: col is 8 bits; row is 9 bits. Address arithmetic is modulo 2^19; no overflow is possible for legal dimensions with the default parameters.
- Total writes per legal frame = W*H, each address exactly once, strictly increasing within a row.

Decomposition:
- Shared package vga_pkg:
  - state enum wr_state_t {IDLE, WAIT_VS, WRITE, FLUSH, DONE}
  - constants H_ACTIVE=640, V_ACTIVE=480, ADDR_W=19, PIX_W=8
  - dimension field positions DIM_W_MSB/LSB and DIM_H_MSB/LSB
- One natural sub-module: vs_edge_detect (registered falling-edge detector on vertical_sync), reusable by the VGA reader.

Test Plan:
- 4x2 frame, start, VS falling edge, pix_valid continuous with data 10..17 -> 8 writes: addr 0,1,2,3,640,641,642,643; data 10..17; done one cycle after the last write; busy low at done.
- Same 4x2 frame with pix_valid toggling 1/0 -> same 8 writes in the same order; mem_we low one cycle after each invalid cycle.
- dimensiones=16'h0003 (W=0) -> no mem_we; dim_err=1; done pulse 1 cycle after start. Then a legal start -> dim_err cleared.
- start while vertical_sync already low -> no pix_ready until VS goes high then low again. pix_valid during WAIT_VS -> no writes.
- Reset asserted after 3 writes of an 8x8 frame -> mem_we=0 next cycle, no done, IDLE. A restart rewrites from BASE_ADDR.
- Full 255x255 frame with second start pulses mid-frame -> exactly 65025 writes, last addr 254*640+254=162814, start pulses ignored.
